// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes and the memory-stage FSM states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational map from an instruction to its data-memory access: direction, address, store data.
module mem_access_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] val_e,
  input  logic [63:0] val_a,
  input  logic [63:0] val_p,
  output logic        is_read,
  output logic        is_write,
  output logic [63:0] addr,
  output logic [63:0] wdata
);

  always_comb begin
    is_read  = (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
    is_write = (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
    // ret/popq read through the old stack pointer carried in valA
    addr     = ((icode == IRET) || (icode == IPOPQ)) ? val_a : val_e;
    wdata    = (icode == ICALL) ? val_p : val_a;
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: one instruction in flight, data-memory access over req/ack, result held for writeback.
module memory_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] DMEM_SIZE = 64'h1_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  input  logic [1:0]  stat_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  icode_o,
  output logic [63:0] valE_o,
  output logic [63:0] valM_o,
  output logic [1:0]  stat_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high; a valid
  // producer holds its payload until that cycle, and ready may depend combinationally on the
  // consumer's ready (HOLD forwards out_ready_i to in_ready_o for back-to-back flow).

  logic [1:0]  state;
  logic        halted;
  logic [15:0] timer;
  logic [3:0]  icode_q;
  logic [63:0] vale_q, valm_q, addr_q, wdata_q;
  logic [1:0]  stat_q;
  logic        we_q, is_read_q;

  logic        dec_read, dec_write;
  logic [63:0] dec_addr, dec_wdata;
  logic        accept;

  mem_access_decode u_decode (
    .icode    (icode_i),
    .val_e    (valE_i),
    .val_a    (valA_i),
    .val_p    (valP_i),
    .is_read  (dec_read),
    .is_write (dec_write),
    .addr     (dec_addr),
    .wdata    (dec_wdata)
  );

  // A faulting result leaving HOLD must not admit a successor in the same cycle.
  assign in_ready_o = !halted && ((state == ST_IDLE) ||
                      ((state == ST_HOLD) && out_ready_i && (stat_q == STAT_AOK)));
  assign accept     = in_valid_i && in_ready_o;

  assign out_valid_o  = (state == ST_HOLD);
  assign dmem_req_o   = (state == ST_ACCESS);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign icode_o      = icode_q;
  assign valE_o       = vale_q;
  assign valM_o       = valm_q;
  assign stat_o       = stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      halted    <= 1'b0;
      timer     <= 16'd0;
      icode_q   <= 4'h0;
      vale_q    <= 64'd0;
      valm_q    <= 64'd0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      stat_q    <= STAT_AOK;
      we_q      <= 1'b0;
      is_read_q <= 1'b0;
    end else begin
      case (state)
        ST_ACCESS: begin
          if (dmem_err_i) begin
            valm_q <= 64'd0;
            stat_q <= STAT_ADR;
            state  <= ST_HOLD;
          end else if (dmem_ack_i) begin
            valm_q <= is_read_q ? dmem_rdata_i : 64'd0;
            stat_q <= STAT_AOK;
            state  <= ST_HOLD;
          end else if (timer == 16'(TIMEOUT - 1)) begin
            valm_q <= 64'd0;
            stat_q <= STAT_ADR;
            state  <= ST_HOLD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            if (stat_q != STAT_AOK) halted <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // Capture overrides the HOLD->IDLE move when a new instruction arrives back-to-back.
      if (accept) begin
        icode_q   <= icode_i;
        vale_q    <= valE_i;
        valm_q    <= 64'd0;
        addr_q    <= dec_addr;
        wdata_q   <= dec_wdata;
        we_q      <= dec_write;
        is_read_q <= dec_read;
        timer     <= 16'd0;
        if ((stat_i != STAT_AOK) || !(dec_read || dec_write)) begin
          stat_q <= stat_i;
          state  <= ST_HOLD;
        end else if (dec_addr >= DMEM_SIZE) begin
          stat_q <= STAT_ADR;
          state  <= ST_HOLD;
        end else begin
          stat_q <= STAT_AOK;
          state  <= ST_ACCESS;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table with a reactive memory responder, plus hand sequences.
module tb_memory_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = 4'h0;
  logic [63:0] vale = 64'd0, vala = 64'd0, valp = 64'd0;
  logic [1:0]  stat_in = STAT_AOK;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode_out;
  logic [63:0] vale_out, valm_out;
  logic [1:0]  stat_out;
  logic        req, we;
  logic [63:0] addr, wdata;
  logic        ack = 1'b0;
  logic [63:0] rdata = 64'd0;
  logic        err = 1'b0;

  int total = 0;
  int bad   = 0;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .icode_i(icode), .valE_i(vale), .valA_i(vala), .valP_i(valp), .stat_i(stat_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .icode_o(icode_out), .valE_o(vale_out), .valM_o(valm_out), .stat_o(stat_out),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata), .dmem_err_i(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vale, vala, valp;
    logic [1:0]  stat;
    int          lat;      // respond on this request cycle (0 = never)
    logic        ack, err;
    logic [63:0] rdata;
    logic        rst_before;
    logic        exp_req, exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_valm;
    logic [1:0]  exp_stat;
    int          exp_lat;  // cycles from capture to out_valid
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_icode", 64'(icode_out), 64'd0);
    chk("rst_vale", vale_out, 64'd0);
    chk("rst_valm", valm_out, 64'd0);
    chk("rst_stat", 64'(stat_out), 64'(STAT_AOK));
    chk("rst_addr", addr, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ack = 1'b0; err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state();
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int req_cyc = 0;
    bit seen_req = 1'b0;
    int acc = 0;
    if (v.rst_before) do_reset();
    icode = v.icode; vale = v.vale; vala = v.vala; valp = v.valp; stat_in = v.stat;
    in_valid = 1'b1;
    #1 chk("in_ready_before", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      ack = 1'b0; err = 1'b0;
      if (out_valid) break;
      if (req) begin
        req_cyc++;
        if (!seen_req) begin
          seen_req = 1'b1;
          chk("req_addr", addr, v.exp_addr);
          chk("req_we", 64'(we), 64'(v.exp_we));
          if (v.exp_we) chk("req_wdata", wdata, v.exp_wdata);
        end
        if (req_cyc == v.lat) begin
          ack = v.ack; err = v.err; rdata = v.rdata;
        end
      end
    end
    chk("latency", 64'(cyc), 64'(v.exp_lat));
    chk("req_seen", 64'(seen_req), 64'(v.exp_req));
    chk("icode_o", 64'(icode_out), 64'(v.icode));
    chk("vale_o", vale_out, v.vale);
    chk("valm_o", valm_out, v.exp_valm);
    chk("stat_o", 64'(stat_out), 64'(v.exp_stat));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (v.exp_stat != STAT_AOK) begin
      icode = INOP; stat_in = STAT_AOK; in_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (in_ready || out_valid) acc++;
      end
      chk("sticky_halt", 64'(acc), 64'd0);
      in_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    //            icode  valE                    valA         valP     stat      lat ack   err   rdata                    rst   req   we    addr         wdata    valm                     stat      lat
    vecs[0]  = '{IOPQ,    64'h2A,                 64'h0,       64'h0,   STAT_AOK, 0, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_AOK, 1};
    vecs[1]  = '{IIRMOVQ, 64'h55,                 64'h99,      64'h0,   STAT_AOK, 0, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_AOK, 1};
    vecs[2]  = '{IMRMOVQ, 64'h100,                64'h7,       64'h0,   STAT_AOK, 3, 1'b1, 1'b0, 64'hDEADBEEF,            1'b0, 1'b1, 1'b0, 64'h100,     64'h0,   64'hDEADBEEF,            STAT_AOK, 4};
    vecs[3]  = '{ICALL,   64'h1F8,                64'h123,     64'h40,  STAT_AOK, 2, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 64'h1F8,     64'h40,  64'h0,                   STAT_AOK, 3};
    vecs[4]  = '{IRMMOVQ, 64'h200,                64'h77,      64'h0,   STAT_AOK, 1, 1'b1, 1'b0, 64'h999,                 1'b0, 1'b1, 1'b1, 64'h200,     64'h77,  64'h0,                   STAT_AOK, 2};
    vecs[5]  = '{IPUSHQ,  64'h3F8,                64'h11,      64'h0,   STAT_AOK, 5, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 64'h3F8,     64'h11,  64'h0,                   STAT_AOK, 6};
    vecs[6]  = '{IRET,    64'h500,                64'h400,     64'h0,   STAT_AOK, 1, 1'b1, 1'b0, 64'hABC,                 1'b0, 1'b1, 1'b0, 64'h400,     64'h0,   64'hABC,                 STAT_AOK, 2};
    vecs[7]  = '{IPOPQ,   64'h1_0000,             64'hFFFF,    64'h0,   STAT_AOK, 2, 1'b1, 1'b0, 64'h5,                   1'b0, 1'b1, 1'b0, 64'hFFFF,    64'h0,   64'h5,                   STAT_AOK, 3};
    vecs[8]  = '{IMRMOVQ, 64'hFFFF,               64'h0,       64'h0,   STAT_AOK, 1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b0, 64'hFFFF,    64'h0,   64'h0123_4567_89AB_CDEF, STAT_AOK, 2};
    vecs[9]  = '{IRMMOVQ, 64'h1_0000,             64'h5,       64'h0,   STAT_AOK, 0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_ADR, 1};
    vecs[10] = '{IPOPQ,   64'h18,                 64'h20,      64'h0,   STAT_AOK, 0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b0, 64'h20,      64'h0,   64'h0,                   STAT_ADR, 17};
    vecs[11] = '{IMRMOVQ, 64'h300,                64'h0,       64'h0,   STAT_AOK, 2, 1'b1, 1'b1, 64'hFF,                  1'b1, 1'b1, 1'b0, 64'h300,     64'h0,   64'h0,                   STAT_ADR, 3};
    vecs[12] = '{INOP,    64'h0,                  64'h0,       64'h0,   STAT_INS, 0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_INS, 1};
    vecs[13] = '{IMRMOVQ, 64'h100,                64'h0,       64'h0,   STAT_HLT, 0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_HLT, 1};
    vecs[14] = '{IMRMOVQ, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,      64'h0,   STAT_AOK, 0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 64'h0,       64'h0,   64'h0,                   STAT_ADR, 1};
    vecs[15] = '{IPUSHQ,  64'h80,                 64'h9,       64'h0,   STAT_AOK, 1, 1'b0, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b1, 64'h80,      64'h9,   64'h0,                   STAT_ADR, 2};

    do_reset();
    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Backpressure on a load result, then back-to-back non-memory stream.
    do_reset();
    icode = IMRMOVQ; vale = 64'h180; vala = 64'h0; stat_in = STAT_AOK; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_req", 64'(req), 64'd1);
    ack = 1'b1; rdata = 64'hCAFE;
    @(negedge clk);
    ack = 1'b0;
    icode = IOPQ; vale = 64'h1000; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_valm", valm_out, 64'hCAFE);
      chk("bp_icode", 64'(icode_out), 64'(IMRMOVQ));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      icode = IOPQ; vale = 64'h1000 + 64'(k); in_valid = 1'b1;
      #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_vale", vale_out, 64'h1000 + 64'(k));
      chk("b2b_valm", valm_out, 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // Reset in the middle of an access, then a stale ack.
    do_reset();
    icode = IMRMOVQ; vale = 64'h40; stat_in = STAT_AOK; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ra_req_before", 64'(req), 64'd1);
    #2 rst = 1'b1;
    #1 chk("ra_req_dropped", 64'(req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1; rdata = 64'h1234;
    @(negedge clk);
    ack = 1'b0;
    chk("ra_late_valid", 64'(out_valid), 64'd0);
    chk("ra_late_ready", 64'(in_ready), 64'd1);
    chk("ra_late_valm", valm_out, 64'd0);
    @(negedge clk);
    chk("ra_still_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
